// File: rtl/secuenciador_temporizado_if.sv
// -----------------------------------------------------------------------------
// secuenciador_temporizado_if
//
// Link between the period sequencer (initiator) and the shared interval timer.
//
// Signals:
//   AbilitarCuenta : count-enable towards the timer; low clears the timer.
//   FinalCuenta    : end-of-count level from the timer; stays high while the
//                    enable is held.
//
// Modports:
//   master : sequencer side (drives AbilitarCuenta, reads FinalCuenta).
//   slave  : timer side (reads AbilitarCuenta, drives FinalCuenta).
// -----------------------------------------------------------------------------
interface secuenciador_temporizado_if;
  logic AbilitarCuenta;
  logic FinalCuenta;

  modport master (
    output AbilitarCuenta,
    input  FinalCuenta
  );

  modport slave (
    input  AbilitarCuenta,
    output FinalCuenta
  );
endinterface

// File: rtl/secuenciador_temporizado.sv
// -----------------------------------------------------------------------------
// secuenciador_temporizado
//
// Runs a requested number of back-to-back periods of a shared interval timer.
// Callers ask for "N periods"; this block drives the timer enable, re-arms the
// timer between periods (enable low until the end-of-count flag drops), and
// reports one Tick per completed period plus a Listo pulse at the end.
//
// Optional feature (compile-time macro SECUENCIADOR_WATCHDOG_EN):
//   A wait counter watches CONTAR/REARMAR. When it reaches ESPERA_MAX cycles in
//   one state the run is abandoned: Error goes high (sticky until the next
//   accepted Iniciar), the enable drops and the block returns to REPOSO with
//   no Listo. Without the macro Error is tied low and the waits are unbounded.
//
// Parameters:
//   W          : width of NumPeriodos / PeriodosHechos.
//   ESPERA_MAX : watchdog limit in cycles (watchdog build only).
//
// Ports:
//   Clk            in   system clock, rising edge.
//   Reset          in   asynchronous active-high reset.
//   Iniciar        in   start request, honoured only in REPOSO.
//   NumPeriodos    in   periods to run, captured with an accepted Iniciar.
//   Cancelar       in   abort, highest priority, back to REPOSO.
//   tmr            if   timer link (master modport).
//   Ocupado        out  high in every state except REPOSO.
//   Tick           out  one-cycle pulse per completed period.
//   Listo          out  one-cycle pulse when all periods are done.
//   PeriodosHechos out  periods completed in the current or last run.
//   Error          out  sticky watchdog flag.
//
// Every output is a register loaded from the next-state decode, so there is
// no combinational path from an input to an output.
// -----------------------------------------------------------------------------
module secuenciador_temporizado #(
  parameter int unsigned W          = 8,
  parameter logic [31:0] ESPERA_MAX = 32'd40_000_000
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              Iniciar,
  input  logic [W-1:0]                      NumPeriodos,
  input  logic                              Cancelar,
  secuenciador_temporizado_if.master        tmr,
  output logic                              Ocupado,
  output logic                              Tick,
  output logic                              Listo,
  output logic [W-1:0]                      PeriodosHechos,
  output logic                              Error
);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CONTAR  = 2'd1,
    REARMAR = 2'd2,
    FIN     = 2'd3
  } estado_t;

  // Counters saturate instead of wrapping.
  function automatic logic [W-1:0] dec_sat(input logic [W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  function automatic logic [W-1:0] inc_sat(input logic [W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  estado_t        estado_q, estado_d;
  logic [W-1:0]   restantes_q, restantes_d;
  logic [W-1:0]   hechos_q, hechos_d;
  logic           abilitar_q, abilitar_d;
  logic           ocupado_q, ocupado_d;
  logic           tick_q, tick_d;
  logic           listo_q, listo_d;

  logic           acepta;       // start request accepted this cycle
  logic           timeout;      // watchdog limit reached in a wait state
  logic           disparo_wd;   // watchdog actually aborts the run

  assign acepta = (estado_q == REPOSO) && Iniciar && !Cancelar;

  // ---------------------------------------------------------------------------
  // Next-state and next-output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    estado_d    = estado_q;
    restantes_d = restantes_q;
    hechos_d    = hechos_q;
    tick_d      = 1'b0;
    disparo_wd  = 1'b0;

    unique case (estado_q)
      REPOSO: begin
        if (acepta) begin
          restantes_d = NumPeriodos;
          hechos_d    = '0;
          estado_d    = (NumPeriodos != '0) ? CONTAR : FIN;
        end
      end

      CONTAR: begin
        // Cancelar wins even over a simultaneous end-of-count.
        if (Cancelar) begin
          estado_d = REPOSO;
        end else if (tmr.FinalCuenta) begin
          restantes_d = dec_sat(restantes_q);
          hechos_d    = inc_sat(hechos_q);
          tick_d      = 1'b1;
          estado_d    = REARMAR;
        end else if (timeout) begin
          disparo_wd = 1'b1;
          estado_d   = REPOSO;
        end
      end

      REARMAR: begin
        // Enable is low here; the timer is only re-armed once its flag has
        // dropped, which guarantees a fresh full period next time.
        if (Cancelar) begin
          estado_d = REPOSO;
        end else if (!tmr.FinalCuenta) begin
          estado_d = (restantes_q != '0) ? CONTAR : FIN;
        end else if (timeout) begin
          disparo_wd = 1'b1;
          estado_d   = REPOSO;
        end
      end

      FIN: begin
        estado_d = REPOSO;
      end

      default: begin
        estado_d = REPOSO;
      end
    endcase

    // Outputs registered from the state being entered.
    abilitar_d = (estado_d == CONTAR);
    ocupado_d  = (estado_d != REPOSO);
    listo_d    = (estado_d == FIN);
  end

`ifdef SECUENCIADOR_WATCHDOG_EN
  logic [31:0] espera_q, espera_d;
  logic        error_q, error_d;
  logic        en_espera;

  assign en_espera = (estado_q == CONTAR) || (estado_q == REARMAR);

  // espera_q counts cycles already spent in the current wait state; the limit
  // fires on the cycle that completes ESPERA_MAX of them.
  assign timeout = en_espera && ((espera_q + 32'd1) >= ESPERA_MAX);

  always_comb begin
    espera_d = espera_q + 32'd1;
    if (!en_espera || (estado_d != estado_q)) begin
      espera_d = '0;
    end

    error_d = error_q;
    if (acepta) begin
      error_d = 1'b0;
    end else if (disparo_wd) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      espera_q <= '0;
      error_q  <= 1'b0;
    end else begin
      espera_q <= espera_d;
      error_q  <= error_d;
    end
  end

  assign Error = error_q;
`else
  logic unused_wd;

  assign timeout   = 1'b0;
  assign Error     = 1'b0;
  assign unused_wd = disparo_wd ^ (^ESPERA_MAX);
`endif

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      estado_q    <= REPOSO;
      restantes_q <= '0;
      hechos_q    <= '0;
      abilitar_q  <= 1'b0;
      ocupado_q   <= 1'b0;
      tick_q      <= 1'b0;
      listo_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      restantes_q <= restantes_d;
      hechos_q    <= hechos_d;
      abilitar_q  <= abilitar_d;
      ocupado_q   <= ocupado_d;
      tick_q      <= tick_d;
      listo_q     <= listo_d;
    end
  end

  assign tmr.AbilitarCuenta = abilitar_q;
  assign Ocupado            = ocupado_q;
  assign Tick               = tick_q;
  assign Listo              = listo_q;
  assign PeriodosHechos     = hechos_q;

endmodule
